// File: rtl/canvas_pkg.sv
// Shared types and constants for the canvas RAM access controller.
// The canvas is 2^COORD_W pixels square, and each pixel holds a COLOR_W-bit colour code.
package canvas_pkg;

    localparam int unsigned COORD_W = 7;
    localparam int unsigned COLOR_W = 3;
    localparam int unsigned ADDR_W  = 2 * COORD_W;

    typedef logic [COLOR_W-1:0] color_t;

    localparam color_t COLOR_ERASE  = 3'b000;
    localparam color_t COLOR_RED    = 3'b100;
    localparam color_t COLOR_GREEN  = 3'b010;
    localparam color_t COLOR_BLUE   = 3'b001;
    localparam color_t COLOR_YELLOW = 3'b110;
    localparam color_t COLOR_PURPLE = 3'b101;
    localparam color_t COLOR_WHITE  = 3'b111;

    typedef enum logic {IDLE, CLEAR} clr_state_t;

    typedef enum logic {SLOT_READ, SLOT_WRITE} slot_t;

    typedef struct packed {
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
        color_t             color;
    } paint_req_t;

endpackage

// File: rtl/canvas_access_ctrl_fifo.sv
// Synchronous pointer-based FIFO that buffers brush paint requests.
// A flush empties the FIFO immediately and takes priority over push and pop.
module paint_fifo
    import canvas_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  paint_req_t din,
    output paint_req_t dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    paint_req_t     mem_q [DEPTH];
    paint_req_t     mem_d [DEPTH];
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;

    // The extra pointer MSB tells a full FIFO apart from an empty one.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign dout  = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push && !full) begin
                mem_d[wr_ptr_q[PTR_W-1:0]] = din;
                wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/canvas_access_ctrl.sv
// Shares the single canvas RAM port between display reads, buffered paint writes and clear sweeps.
// Even (READ) slots always serve the display. Odd (WRITE) slots serve the clear sweep first, then the paint FIFO.
module canvas_access_ctrl
    import canvas_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] rd_x,
    input  logic [COORD_W-1:0] rd_y,
    output logic [COLOR_W-1:0] rd_data,
    output logic               rd_valid,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [COLOR_W-1:0] wr_color,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               clear_busy,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [COLOR_W-1:0] ram_wdata,
    input  logic [COLOR_W-1:0] ram_rdata
);

    slot_t           slot_q, slot_d;
    clr_state_t      state_q, state_d;
    logic [ADDR_W:0] clr_addr_q, clr_addr_d;
    color_t          clr_color_q, clr_color_d;
    color_t          rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;

    logic            clear_start;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    paint_req_t      fifo_din, fifo_dout;

    assign clear_start = (state_q == IDLE) && clear_req;
    assign wr_ready    = !fifo_full && !clear_start;
    assign fifo_push   = wr_valid && wr_ready;
    assign fifo_din    = '{y: wr_y, x: wr_x, color: wr_color};

    paint_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clear_start),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        slot_d      = (slot_q == SLOT_READ) ? SLOT_WRITE : SLOT_READ;
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        clr_color_d = clr_color_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        fifo_pop    = 1'b0;
        ram_addr    = '0;
        ram_we      = 1'b0;
        ram_wdata   = '0;

        // The cycle after a READ slot carries that slot's RAM data.
        if (slot_q == SLOT_WRITE) begin
            rd_data_d  = ram_rdata;
            rd_valid_d = 1'b1;
        end

        if (slot_q == SLOT_READ) begin
            ram_addr = {rd_y, rd_x};
        end else if (state_q == CLEAR) begin
            ram_we     = 1'b1;
            ram_addr   = clr_addr_q[ADDR_W-1:0];
            ram_wdata  = clr_color_q;
            clr_addr_d = clr_addr_q + (ADDR_W+1)'(1);
            if (clr_addr_d[ADDR_W]) begin
                state_d    = IDLE;
                clr_addr_d = '0;
            end
        end else if (!fifo_empty && !clear_start) begin
            // A clear starting in this cycle discards the head along with the rest of the FIFO.
            fifo_pop  = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = {fifo_dout.y, fifo_dout.x};
            ram_wdata = fifo_dout.color;
        end

        if (clear_start) begin
            state_d     = CLEAR;
            clr_addr_d  = '0;
            clr_color_d = clear_color;
        end

        if (reset) begin
            ram_we    = 1'b0;
            ram_addr  = '0;
            ram_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q      <= SLOT_READ;
            state_q     <= IDLE;
            clr_addr_q  <= '0;
            clr_color_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            clr_color_q <= clr_color_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign clear_busy = (state_q == CLEAR);

endmodule
